// File: rtl/reg_write_back_arbiter_pkg.sv
// Shared widths, index helper and source-slot constants for the register write-back stage.
package wb_pkg;

    localparam int DEFAULT_NUM_SRC    = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_FPU = 2;
    localparam int SRC_CSR = 3;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_write_back_arbiter_rr_arbiter.sv
// Round-robin grant: search starts at ptr and wraps; lowest rotated offset with a request wins.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [W-1:0] cand_idx [N];
    logic [N-1:0] req_rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign cand_idx[gi] = W'((int'(ptr) + gi) % N);
            assign req_rot[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Walk from the far end so the nearest offset to ptr is the last assignment.
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req_rot[k]) begin
                any     = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/reg_write_back_arbiter.sv
// Merges NUM_SRC result streams into one registered register-file write port.
module reg_write_back_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = DEFAULT_NUM_SRC,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wb_stall,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   src_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic                            rf_we,
    output logic [ADDR_WIDTH-1:0]           rf_addr,
    output logic [DATA_WIDTH-1:0]           rf_data,
    output logic [clog2(NUM_SRC)-1:0]       grant_src
);

    localparam int IDX_W = clog2(NUM_SRC);

    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      rr_ptr_next;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [NUM_SRC-1:0]    gnt;
    logic [ADDR_WIDTH-1:0] rd_arr   [NUM_SRC];
    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_we_reg;
    logic [ADDR_WIDTH-1:0] rf_addr_reg;
    logic [DATA_WIDTH-1:0] rf_data_reg;
    logic [IDX_W-1:0]      grant_src_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign rd_arr[gi]   = src_rd[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Gating with rst_n keeps ready low for the whole reset window, not just at edges.
    rr_arbiter #(
        .N (NUM_SRC),
        .W (IDX_W)
    ) u_rr_arbiter (
        .req     (src_valid),
        .ptr     (rr_ptr_reg),
        .en      (~wb_stall & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign src_ready = gnt;
    assign sel_rd    = rd_arr[gnt_idx];
    assign sel_data  = data_arr[gnt_idx];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_any) begin
            rr_ptr_next = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            rf_we_reg     <= 1'b0;
            rf_addr_reg   <= '0;
            rf_data_reg   <= '0;
            grant_src_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            // x0 writes complete the handshake but never reach the register file.
            rf_we_reg  <= gnt_any && (sel_rd != '0);
            if (gnt_any) begin
                rf_addr_reg   <= sel_rd;
                rf_data_reg   <= sel_data;
                grant_src_reg <= gnt_idx;
            end
        end
    end

    assign rf_we     = rf_we_reg;
    assign rf_addr   = rf_addr_reg;
    assign rf_data   = rf_data_reg;
    assign grant_src = grant_src_reg;

endmodule
